// File: rtl/mux2_1.sv
// Packet-aware 2-to-1 AXI-Stream merger: round-robin arbitration at frame
// boundaries, source-port tag on every beat, fully registered 2-entry skid output.
module mux2_1 #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] s0_axis_tdata,
    input  logic             s0_axis_tvalid,
    input  logic             s0_axis_tlast,
    output logic             s0_axis_tready,
    input  logic [width-1:0] s1_axis_tdata,
    input  logic             s1_axis_tvalid,
    input  logic             s1_axis_tlast,
    output logic             s1_axis_tready,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tid,
    input  logic             m_axis_tready
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t             state, state_nx;
    logic               last_gnt;
    logic               frame_open;

    logic               out_valid, out_last, out_id;
    logic [width-1:0]   out_data;
    logic               skid_valid, skid_last, skid_id;
    logic [width-1:0]   skid_data;

    logic               s0_rdy, s1_rdy;
    logic               acc, acc_last, acc_id;
    logic [width-1:0]   acc_data;

    always_comb begin
        s0_rdy   = (state == GNT0) && !skid_valid && !rst;
        s1_rdy   = (state == GNT1) && !skid_valid && !rst;
        acc_id   = (state == GNT1);
        acc      = (s0_axis_tvalid && s0_rdy) || (s1_axis_tvalid && s1_rdy);
        acc_data = acc_id ? s1_axis_tdata : s0_axis_tdata;
        acc_last = acc_id ? s1_axis_tlast : s0_axis_tlast;
    end

    assign s0_axis_tready = s0_rdy;
    assign s1_axis_tready = s1_rdy;

    // A granted port that goes quiet between frames hands the grant over,
    // otherwise the other port could starve behind an idle owner.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid)
                    state_nx = last_gnt ? GNT0 : GNT1;
                else if (s0_axis_tvalid)
                    state_nx = GNT0;
                else if (s1_axis_tvalid)
                    state_nx = GNT1;
            end
            GNT0: begin
                if (acc && acc_last)
                    state_nx = s1_axis_tvalid ? GNT1 : (s0_axis_tvalid ? GNT0 : IDLE);
                else if (!frame_open && !s0_axis_tvalid)
                    state_nx = s1_axis_tvalid ? GNT1 : IDLE;
            end
            GNT1: begin
                if (acc && acc_last)
                    state_nx = s0_axis_tvalid ? GNT0 : (s1_axis_tvalid ? GNT1 : IDLE);
                else if (!frame_open && !s1_axis_tvalid)
                    state_nx = s0_axis_tvalid ? GNT0 : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            frame_open <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc) begin
                frame_open <= !acc_last;
                if (acc_last)
                    last_gnt <= acc_id;
            end
        end
    end

    // Output register: refilled from skid first, then from a newly accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_id     <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (m_axis_tready) begin
                out_data   <= skid_data;
                out_last   <= skid_last;
                out_id     <= skid_id;
                skid_valid <= 1'b0;
            end
        end else if (acc) begin
            if (!out_valid || m_axis_tready) begin
                out_valid <= 1'b1;
                out_data  <= acc_data;
                out_last  <= acc_last;
                out_id    <= acc_id;
            end else begin
                skid_valid <= 1'b1;
            end
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc && !skid_valid && out_valid && !m_axis_tready) begin
            skid_data <= acc_data;
            skid_last <= acc_last;
            skid_id   <= acc_id;
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;
    assign m_axis_tid    = out_id;

endmodule

// File: doc/mux2_1.md
# mux2_1

Packet-aware 2-to-1 AXI-Stream merger, the counterpart of the 1-to-2 stream distributor: it collects frames arriving on two input streams and forwards them, whole and unbroken, onto a single output stream. It arbitrates round-robin at frame boundaries. It tags every output beat with its source port so a downstream distributor can split the stream again. The output is fully registered through a 2-entry skid buffer, so no combinational path exists from m_axis_tready to s*_axis_tready.

## Interface
- width, 1, bit width of s0/s1/m tdata

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- s0_axis_tdata  input  width  port-0 data
- s0_axis_tvalid  input  1  port-0 data valid
- s0_axis_tlast  input  1  port-0 end of frame
- s0_axis_tready  output  1  port-0 accept
- s1_axis_tdata  input  width  port-1 data
- s1_axis_tvalid  input  1  port-1 data valid
- s1_axis_tlast  input  1  port-1 end of frame
- s1_axis_tready  output  1  port-1 accept
- m_axis_tdata  output  width  merged data
- m_axis_tvalid  output  1  merged data valid
- m_axis_tlast  output  1  merged end of frame
- m_axis_tid  output  1  source port of current beat (0 or 1)
- m_axis_tready  input  1  downstream accept

## Operation
- Handshakes:
  - A beat transfers when valid and ready are both high at a rising edge.
  - Inputs may hold tvalid high indefinitely.
  - m_axis_tdata, m_axis_tlast and m_axis_tid are stable while m_axis_tvalid=1 and m_axis_tready=0.
- State machine states: IDLE, GNT0, GNT1. Register last_gnt records the port of the last completed frame.
- IDLE:
  - If exactly one sN_axis_tvalid is high, go to GNTN.
  - If both are high, go to the port other than last_gnt.
  - If neither is high, stay in IDLE.
  - No input is accepted in IDLE.
- GNTN:
  - sN_axis_tready = ~skid_valid; the other port's tready = 0.
  - A beat accepted with sN_axis_tlast=1 ends the frame and sets last_gnt<=N. The next state is chosen in the same cycle:
    - GNT(other) if the other port's tvalid is high;
    - else GNTN if sN_axis_tvalid is high;
    - else IDLE.
  - The state never changes mid-frame, regardless of the other port's activity.
- Output stage has two registers, out (drives m_axis_*) and skid:
  - An accepted beat goes to out if out is empty or m_axis_tready=1; otherwise it goes to skid.
  - When m_axis_tready=1 and skid is full, out<=skid and skid is cleared.
  - m_axis_tid holds the granted port captured with the beat.
- Frames are never interleaved on m_axis; beat order within a frame is preserved. Zero-length frames do not exist: a single beat with tlast=1 is a one-beat frame.

## Timing
- Reset (rst high at a rising edge) sets:
  - state=IDLE, last_gnt=1 (port 0 wins the first tie);
  - out and skid empty;
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0;
  - s0_axis_tready=0, s1_axis_tready=0.
- s0_axis_tready and s1_axis_tready are additionally gated low combinationally in any cycle where rst=1.
- Reset mid-frame discards buffered beats and the partial frame. There is no tlast repair; upstream is reset together.
- Grant latency: a request seen in IDLE at edge k gives tready high in cycle k+1. The first beat is accepted at edge k+1 at the earliest.
- Data latency: a beat accepted at edge j drives m_axis_tvalid=1 from edge j onward, i.e. visible in cycle j+1. This is a 1-cycle pipeline.
- Throughput:
  - 1 beat/cycle sustained while m_axis_tready=1.
  - Back-to-back frames, whether switching or staying on a port, need no IDLE bubble.
  - From IDLE there is exactly 1 bubble cycle.
- Backpressure: when m_axis_tready drops, at most one further beat is absorbed into skid. tready falls the cycle after skid fills and rises the cycle after skid drains.
- Simultaneous events:
  - tlast accept and m_axis_tready=0 in the same cycle: the beat goes to skid normally; the grant decision is unaffected.
  - Both ports valid at a frame end: the grant alternates.

## Test plan
- Single frame: after reset, s0 sends 4 beats 0xA0..0xA3 (tlast on 0xA3) with m_axis_tready=1. Required on m_axis: 0xA0..0xA3 in 4 consecutive cycles, tid=0, tlast only on 0xA3, first m_axis_tvalid 2 cycles after s0_axis_tvalid rises.
- Fairness: both ports continuously offer 3-beat frames (s0 0x1x, s1 0x2x). Required: output frames alternate s0,s1,s0,s1, starting with s0, with no gaps between frames and tid matching.
- Frame lock: s0 starts an 8-beat frame; s1 raises tvalid at beat 2. Required: all 8 s0 beats are output contiguously before any s1 beat, and s1_axis_tready=0 throughout.
- Backpressure: random m_axis_tready (50%) over 200 beats from both ports. Required:
  - output data sequence per tid equals the input sequence per port;
  - no beat lost or duplicated;
  - m_axis_* stable while stalled;
  - tready never high while skid is full.
- Reset mid-frame: assert rst for 1 cycle during beat 3 of a 6-beat s1 frame. Required:
  - next cycle m_axis_tvalid=0 and both tready=0;
  - after reset a fresh s0 frame passes intact with tid=0.
